sr_latch_driver: RTL

SR_LATCH_DRIVER -- requirements
Module: sr_latch_driver

---
 rtl/sr_latch_driver.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/sr_latch_driver.sv
// Drives the S/R inputs of an external SR latch with fixed-width, non-overlapping
// pulses, then reads the latch output back and flags mismatches.
`timescale 1ns/1ps

module sr_latch_driver #(
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned GUARD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic       cmd_set,
  output logic       cmd_ready,
  output logic       S,
  output logic       R,
  input  logic       Q,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] err_cnt
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned ECNT_W  = 8;
  localparam logic [ECNT_W-1:0] ECNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GUARD = 2'd2,
    CHECK = 2'd3
  } state_t;

  state_t              state;
  state_t              state_n;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_n;
  logic                set_q;
  logic                set_n;

  logic                ready_n;
  logic                s_n;
  logic                r_n;
  logic                busy_n;
  logic                done_n;
  logic                err_n;
  logic [ECNT_W-1:0]   err_cnt_n;

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      set_q     <= 1'b0;
      cmd_ready <= 1'b1;
      S         <= 1'b0;
      R         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      set_q     <= set_n;
      cmd_ready <= ready_n;
      S         <= s_n;
      R         <= r_n;
      busy      <= busy_n;
      done      <= done_n;
      err       <= err_n;
      err_cnt   <= err_cnt_n;
    end
  end

  // Next state and the output values for the cycle after this edge.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    set_n     = set_q;
    ready_n   = 1'b0;
    s_n       = 1'b0;
    r_n       = 1'b0;
    busy_n    = 1'b1;
    done_n    = 1'b0;
    err_n     = 1'b0;
    err_cnt_n = err_cnt;

    case (state)
      IDLE: begin
        busy_n  = 1'b0;
        ready_n = 1'b1;
        if (cmd_valid) begin
          state_n = PULSE;
          cnt_n   = CNT_W'(PULSE_CYCLES - 1);
          set_n   = cmd_set;
          s_n     = cmd_set;
          r_n     = ~cmd_set;
          busy_n  = 1'b1;
          ready_n = 1'b0;
        end
      end

      PULSE: begin
        if (cnt == '0) begin
          state_n = GUARD;
          cnt_n   = CNT_W'(GUARD_CYCLES - 1);
        end else begin
          cnt_n = CNT_W'(cnt - 1'b1);
          s_n   = set_q;
          r_n   = ~set_q;
        end
      end

      // Q is only looked at on the edge that ends the last guard cycle.
      GUARD: begin
        if (cnt == '0) begin
          state_n = CHECK;
          done_n  = 1'b1;
          err_n   = (Q != set_q);
          if (err_n && (err_cnt != ECNT_MAX)) begin
            err_cnt_n = ECNT_W'(err_cnt + 1'b1);
          end
        end else begin
          cnt_n = CNT_W'(cnt - 1'b1);
        end
      end

      CHECK: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        ready_n = 1'b1;
      end

      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        ready_n = 1'b1;
      end
    endcase
  end

endmodule
